rc4_encrypt_fsm: RTL and testbench

RC4_ENCRYPT_FSM -- requirements
Module: rc4_encrypt_fsm

---
 rtl/rc4_encrypt_fsm.sv | 170 +++++++++++++++++
 tb/tb_rc4_encrypt_fsm.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_encrypt_fsm.sv
// rtl/rc4_encrypt_fsm.sv - RC4 PRGA encryptor over external S, plaintext and ciphertext memories
module rc4_encrypt_fsm #(
    parameter int MSG_DEP = 32,
    parameter int MSG_AW  = 5
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              start,
    output logic [7:0]        s_address,
    output logic [7:0]        s_data,
    output logic              s_wren,
    input  logic [7:0]        s_q,
    output logic [MSG_AW-1:0] pt_address,
    input  logic [7:0]        pt_q,
    output logic [MSG_AW-1:0] ct_address,
    output logic [7:0]        ct_data,
    output logic              ct_wren,
    output logic              busy,
    output logic              done
);

    typedef enum logic [3:0] {
        IDLE, RD_I, WT_I, RD_J, WT_J, WR_I, WR_J, RD_T, WT_T, WR_CT, DONE
    } state_t;

    localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_DEP - 1);

    state_t            state_q, state_d;
    logic [7:0]        i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d, pt_byte_q, pt_byte_d;
    logic [MSG_AW-1:0] k_q, k_d;

    logic [7:0]        s_address_q, s_address_d, s_data_q, s_data_d, ct_data_q, ct_data_d;
    logic [MSG_AW-1:0] pt_address_q, pt_address_d, ct_address_q, ct_address_d;
    logic              s_wren_q, s_wren_d, ct_wren_q, ct_wren_d, busy_q, busy_d, done_q, done_d;

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        si_d      = si_q;
        sj_d      = sj_q;
        pt_byte_d = pt_byte_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    i_d     = 8'd1;
                    j_d     = 8'd0;
                    k_d     = '0;
                    state_d = RD_I;
                end
            end
            RD_I: state_d = WT_I;
            WT_I: state_d = RD_J;
            RD_J: begin
                si_d      = s_q;
                pt_byte_d = pt_q;
                j_d       = j_q + s_q;
                state_d   = WT_J;
            end
            WT_J: state_d = WR_I;
            WR_I: begin
                sj_d    = s_q;
                state_d = WR_J;
            end
            WR_J: state_d = RD_T;
            RD_T: state_d = WT_T;
            WT_T: state_d = WR_CT;
            WR_CT: begin
                if (k_q == K_LAST) begin
                    state_d = DONE;
                end else begin
                    k_d     = k_q + MSG_AW'(1);
                    i_d     = i_q + 8'd1;
                    state_d = RD_I;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are computed for the state being entered.
        // Every s_q used here is the read data already valid in the current cycle.
        s_address_d  = 8'd0;
        s_data_d     = 8'd0;
        s_wren_d     = 1'b0;
        pt_address_d = '0;
        ct_address_d = '0;
        ct_data_d    = 8'd0;
        ct_wren_d    = 1'b0;

        case (state_d)
            RD_I, WT_I: begin
                s_address_d  = i_d;
                pt_address_d = k_d;
            end
            RD_J:  s_address_d = j_q + s_q;
            WT_J:  s_address_d = j_d;
            WR_I: begin
                s_address_d = i_d;
                s_data_d    = s_q;
                s_wren_d    = 1'b1;
            end
            WR_J: begin
                s_address_d = j_d;
                s_data_d    = si_d;
                s_wren_d    = 1'b1;
            end
            RD_T, WT_T: s_address_d = si_d + sj_d;
            WR_CT: begin
                ct_address_d = k_d;
                ct_data_d    = s_q ^ pt_byte_d;
                ct_wren_d    = 1'b1;
            end
            default: ;
        endcase

        busy_d = (state_d != IDLE) && (state_d != DONE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            i_q          <= 8'd0;
            j_q          <= 8'd0;
            k_q          <= '0;
            si_q         <= 8'd0;
            sj_q         <= 8'd0;
            pt_byte_q    <= 8'd0;
            s_address_q  <= 8'd0;
            s_data_q     <= 8'd0;
            s_wren_q     <= 1'b0;
            pt_address_q <= '0;
            ct_address_q <= '0;
            ct_data_q    <= 8'd0;
            ct_wren_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            j_q          <= j_d;
            k_q          <= k_d;
            si_q         <= si_d;
            sj_q         <= sj_d;
            pt_byte_q    <= pt_byte_d;
            s_address_q  <= s_address_d;
            s_data_q     <= s_data_d;
            s_wren_q     <= s_wren_d;
            pt_address_q <= pt_address_d;
            ct_address_q <= ct_address_d;
            ct_data_q    <= ct_data_d;
            ct_wren_q    <= ct_wren_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign s_address  = s_address_q;
    assign s_data     = s_data_q;
    assign s_wren     = s_wren_q;
    assign pt_address = pt_address_q;
    assign ct_address = ct_address_q;
    assign ct_data    = ct_data_q;
    assign ct_wren    = ct_wren_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_rc4_encrypt_fsm.sv
// tb/tb_rc4_encrypt_fsm.sv - randomized bench for rc4_encrypt_fsm against an array-based RC4 model
module tb_rc4_encrypt_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n = 1'b0;
    logic start_a = 1'b0, start_b = 1'b0;

    logic [7:0] s_address_a, s_data_a, ct_data_a, s_q_a = 8'd0, pt_q_a = 8'd0;
    logic       s_wren_a, ct_wren_a, busy_a, done_a;
    logic [4:0] pt_address_a, ct_address_a;

    logic [7:0] s_address_b, s_data_b, ct_data_b, s_q_b = 8'd0, pt_q_b = 8'd0;
    logic       s_wren_b, ct_wren_b, busy_b, done_b;
    logic [7:0] pt_address_b, ct_address_b;

    rc4_encrypt_fsm #(.MSG_DEP(32), .MSG_AW(5)) dut_a (
        .CLOCK_50(clk), .reset_n(reset_n), .start(start_a),
        .s_address(s_address_a), .s_data(s_data_a), .s_wren(s_wren_a), .s_q(s_q_a),
        .pt_address(pt_address_a), .pt_q(pt_q_a),
        .ct_address(ct_address_a), .ct_data(ct_data_a), .ct_wren(ct_wren_a),
        .busy(busy_a), .done(done_a)
    );

    rc4_encrypt_fsm #(.MSG_DEP(256), .MSG_AW(8)) dut_b (
        .CLOCK_50(clk), .reset_n(reset_n), .start(start_b),
        .s_address(s_address_b), .s_data(s_data_b), .s_wren(s_wren_b), .s_q(s_q_b),
        .pt_address(pt_address_b), .pt_q(pt_q_b),
        .ct_address(ct_address_b), .ct_data(ct_data_b), .ct_wren(ct_wren_b),
        .busy(busy_b), .done(done_b)
    );

    logic [7:0] s_init [256];
    logic [7:0] pt_init[256];
    logic [7:0] s_mem_a[256], pt_mem_a[256], ct_mem_a[256];
    logic [7:0] s_mem_b[256], pt_mem_b[256], ct_mem_b[256];
    logic       ld_a = 1'b0, ld_b = 1'b0;

    always @(posedge clk) begin
        if (ld_a) begin
            s_mem_a  <= s_init;
            pt_mem_a <= pt_init;
            for (int x = 0; x < 256; x++) ct_mem_a[x] <= 8'h5a;
        end else begin
            if (s_wren_a) s_mem_a[s_address_a] <= s_data_a;
            if (ct_wren_a) ct_mem_a[{3'b000, ct_address_a}] <= ct_data_a;
        end
        s_q_a  <= s_mem_a[s_address_a];
        pt_q_a <= pt_mem_a[{3'b000, pt_address_a}];
    end

    always @(posedge clk) begin
        if (ld_b) begin
            s_mem_b  <= s_init;
            pt_mem_b <= pt_init;
            for (int x = 0; x < 256; x++) ct_mem_b[x] <= 8'h5a;
        end else begin
            if (s_wren_b) s_mem_b[s_address_b] <= s_data_b;
            if (ct_wren_b) ct_mem_b[ct_address_b] <= ct_data_b;
        end
        s_q_b  <= s_mem_b[s_address_b];
        pt_q_b <= pt_mem_b[pt_address_b];
    end

    int   n_swr_a = 0, n_ctwr_a = 0, n_dbl_a = 0, n_both_a = 0, n_ctwr_b = 0, last_ct_b = -1;
    logic ct_prev_a = 1'b0;
    int   ct_log[4096];

    always @(negedge clk) begin
        ct_prev_a <= ct_wren_a;
        if (s_wren_a) n_swr_a <= n_swr_a + 1;
        if (ct_wren_a) begin
            n_ctwr_a <= n_ctwr_a + 1;
            if (n_ctwr_a < 4096) ct_log[n_ctwr_a] <= int'(ct_address_a);
            if (ct_prev_a) n_dbl_a <= n_dbl_a + 1;
        end
        if (s_wren_a && ct_wren_a) n_both_a <= n_both_a + 1;
        if (ct_wren_b) begin
            n_ctwr_b  <= n_ctwr_b + 1;
            last_ct_b <= int'(ct_address_b);
        end
    end

    int n_cmp = 0, n_fail = 0;

    logic [7:0] m_s[256], m_pt[256], m_ct[256];

    function automatic void model_prga(input int n);
        int i = 0, j = 0;
        logic [7:0] t;
        for (int k = 0; k < n; k++) begin
            i = (i + 1) % 256;
            j = (j + int'(m_s[i])) % 256;
            t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
            m_ct[k] = m_pt[k] ^ m_s[(int'(m_s[i]) + int'(m_s[j])) % 256];
        end
    endfunction

    function automatic void model_identity();
        for (int x = 0; x < 256; x++) m_s[x] = 8'(x);
    endfunction

    function automatic void model_ksa();
        logic [7:0] key[3];
        logic [7:0] t;
        int j = 0;
        key[0] = 8'h00; key[1] = 8'h02; key[2] = 8'h49;
        model_identity();
        for (int x = 0; x < 256; x++) begin
            j = (j + int'(m_s[x]) + int'(key[x % 3])) % 256;
            t = m_s[x]; m_s[x] = m_s[j]; m_s[j] = t;
        end
    endfunction

    function automatic void model_random_perm();
        logic [7:0] t;
        int y;
        model_identity();
        for (int x = 255; x > 0; x--) begin
            y = $urandom_range(x, 0);
            t = m_s[x]; m_s[x] = m_s[y]; m_s[y] = t;
        end
    endfunction

    function automatic void push_init();
        for (int x = 0; x < 256; x++) begin
            s_init[x]  = m_s[x];
            pt_init[x] = m_pt[x];
        end
    endfunction

    task automatic do_load(input bit b);
        @(negedge clk);
        if (b) ld_b = 1'b1; else ld_a = 1'b1;
        @(negedge clk);
        ld_a = 1'b0;
        ld_b = 1'b0;
    endtask

    task automatic do_start(input bit b, input bit hold);
        @(negedge clk);
        if (b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) begin
            start_a = 1'b0;
            start_b = 1'b0;
        end
    endtask

    task automatic wait_done(input bit b, input int elapsed, output int cycles);
        cycles = -1;
        for (int c = elapsed + 1; c <= elapsed + 3000; c++) begin
            @(posedge clk);
            #1;
            if (b ? done_b : done_a) begin
                cycles = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy_a, done_a, s_wren_a, ct_wren_a, busy_b, done_b, s_wren_b, ct_wren_b} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 00000000",
                     {busy_a, done_a, s_wren_a, ct_wren_a, busy_b, done_b, s_wren_b, ct_wren_b});
        end
        n_cmp++;
        if ({s_address_a, s_data_a, ct_data_a, pt_address_a, ct_address_a} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_bus: got %h want 0", {s_address_a, s_data_a, ct_data_a, pt_address_a, ct_address_a});
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy_a, done_a, busy_b, done_b} !== 4'd0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b want 0000", {busy_a, done_a, busy_b, done_b});
        end
    endtask

    task automatic test_identity();
        int cyc;
        model_identity();
        for (int x = 0; x < 256; x++) m_pt[x] = 8'h00;
        push_init();
        do_load(1'b0);
        model_prga(32);
        do_start(1'b0, 1'b0);
        repeat (17) @(posedge clk);
        #1;
        n_cmp++;
        if (s_mem_a[2] !== 8'h03 || s_mem_a[3] !== 8'h02) begin
            n_fail++;
            $display("FAIL ident_swap: got S2=%h S3=%h want 03 02", s_mem_a[2], s_mem_a[3]);
        end
        wait_done(1'b0, 17, cyc);
        n_cmp++;
        if (ct_mem_a[0] !== 8'h02 || ct_mem_a[1] !== 8'h05) begin
            n_fail++;
            $display("FAIL ident_ct01: got %h %h want 02 05", ct_mem_a[0], ct_mem_a[1]);
        end
        for (int k = 0; k < 32; k++) begin
            n_cmp++;
            if (ct_mem_a[k] !== m_ct[k]) begin
                n_fail++;
                $display("FAIL ident_ct[%0d]: got %h want %h", k, ct_mem_a[k], m_ct[k]);
            end
        end
    endtask

    task automatic test_timing();
        int cyc, b_sw, b_ct, b_dbl, b_both;
        model_random_perm();
        for (int x = 0; x < 256; x++) m_pt[x] = 8'($urandom);
        push_init();
        do_load(1'b0);
        b_sw = n_swr_a; b_ct = n_ctwr_a; b_dbl = n_dbl_a; b_both = n_both_a;
        do_start(1'b0, 1'b0);
        wait_done(1'b0, 0, cyc);
        @(negedge clk);
        n_cmp++;
        if (cyc !== 288) begin
            n_fail++;
            $display("FAIL timing_done: got %0d cycles want 288", cyc);
        end
        n_cmp++;
        if (n_ctwr_a - b_ct !== 32 || n_swr_a - b_sw !== 64) begin
            n_fail++;
            $display("FAIL timing_pulses: got ct=%0d s=%0d want ct=32 s=64", n_ctwr_a - b_ct, n_swr_a - b_sw);
        end
        n_cmp++;
        if (n_dbl_a - b_dbl !== 0 || n_both_a - b_both !== 0) begin
            n_fail++;
            $display("FAIL timing_overlap: got dbl=%0d both=%0d want 0 0", n_dbl_a - b_dbl, n_both_a - b_both);
        end
        for (int x = 0; x < 32; x++) begin
            n_cmp++;
            if (ct_log[b_ct + x] !== x) begin
                n_fail++;
                $display("FAIL timing_addr[%0d]: got %0d want %0d", x, ct_log[b_ct + x], x);
            end
        end
    endtask

    task automatic test_random();
        int cyc, bad;
        for (int it = 0; it < 3; it++) begin
            model_random_perm();
            for (int x = 0; x < 256; x++) m_pt[x] = 8'($urandom);
            push_init();
            do_load(1'b0);
            model_prga(32);
            do_start(1'b0, 1'b0);
            wait_done(1'b0, 0, cyc);
            for (int k = 0; k < 32; k++) begin
                n_cmp++;
                if (ct_mem_a[k] !== m_ct[k]) begin
                    n_fail++;
                    $display("FAIL rand%0d_ct[%0d]: got %h want %h", it, k, ct_mem_a[k], m_ct[k]);
                end
            end
            bad = 0;
            for (int x = 0; x < 256; x++) if (s_mem_a[x] !== m_s[x]) bad++;
            n_cmp++;
            if (bad !== 0) begin
                n_fail++;
                $display("FAIL rand%0d_s_final: got %0d differing bytes want 0", it, bad);
            end
        end
    endtask

    task automatic test_roundtrip();
        logic [255:0] msg;
        logic [7:0]   pbyte;
        int cyc;
        msg = "attack at dawn, retreat at dusk!";
        model_ksa();
        for (int k = 0; k < 32; k++) m_pt[k] = msg[255 - 8 * k -: 8];
        push_init();
        do_load(1'b0);
        model_prga(32);
        do_start(1'b0, 1'b0);
        wait_done(1'b0, 0, cyc);
        for (int k = 0; k < 32; k++) begin
            n_cmp++;
            if (ct_mem_a[k] !== m_ct[k]) begin
                n_fail++;
                $display("FAIL rt_enc[%0d]: got %h want %h", k, ct_mem_a[k], m_ct[k]);
            end
        end
        model_ksa();
        for (int k = 0; k < 32; k++) m_pt[k] = ct_mem_a[k];
        push_init();
        do_load(1'b0);
        do_start(1'b0, 1'b0);
        wait_done(1'b0, 0, cyc);
        for (int k = 0; k < 32; k++) begin
            pbyte = msg[255 - 8 * k -: 8];
            n_cmp++;
            if (ct_mem_a[k] !== pbyte) begin
                n_fail++;
                $display("FAIL rt_dec[%0d]: got %h want %h", k, ct_mem_a[k], pbyte);
            end
        end
    endtask

    task automatic test_reset_mid();
        int cyc, b_sw, b_ct;
        model_identity();
        for (int x = 0; x < 256; x++) m_pt[x] = 8'h00;
        push_init();
        do_load(1'b0);
        do_start(1'b0, 1'b0);
        repeat (100) @(posedge clk);
        #3;
        n_cmp++;
        if (busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy_before: got %b want 1", busy_a);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy_a, done_a, s_wren_a, ct_wren_a} !== 4'd0 || s_address_a !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_async_clear: got ctrl=%b s_addr=%h want 0000 00",
                     {busy_a, done_a, s_wren_a, ct_wren_a}, s_address_a);
        end
        b_sw = n_swr_a; b_ct = n_ctwr_a;
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (n_swr_a - b_sw !== 0 || n_ctwr_a - b_ct !== 0) begin
            n_fail++;
            $display("FAIL mid_no_writes: got s=%0d ct=%0d want 0 0", n_swr_a - b_sw, n_ctwr_a - b_ct);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_stay_idle: got busy=%b want 0", busy_a);
        end
        model_identity();
        push_init();
        do_load(1'b0);
        model_prga(32);
        do_start(1'b0, 1'b0);
        wait_done(1'b0, 0, cyc);
        n_cmp++;
        if (ct_mem_a[0] !== 8'h02 || ct_mem_a[1] !== 8'h05) begin
            n_fail++;
            $display("FAIL mid_rerun_ct01: got %h %h want 02 05", ct_mem_a[0], ct_mem_a[1]);
        end
        for (int k = 0; k < 32; k++) begin
            n_cmp++;
            if (ct_mem_a[k] !== m_ct[k]) begin
                n_fail++;
                $display("FAIL mid_rerun_ct[%0d]: got %h want %h", k, ct_mem_a[k], m_ct[k]);
            end
        end
    endtask

    task automatic test_start_held();
        int cyc;
        model_random_perm();
        for (int x = 0; x < 256; x++) m_pt[x] = 8'($urandom);
        push_init();
        do_load(1'b0);
        model_prga(32);
        do_start(1'b0, 1'b1);
        wait_done(1'b0, 0, cyc);
        start_a = 1'b0;
        n_cmp++;
        if (cyc !== 288) begin
            n_fail++;
            $display("FAIL held_done: got %0d cycles want 288", cyc);
        end
        for (int k = 0; k < 32; k++) begin
            n_cmp++;
            if (ct_mem_a[k] !== m_ct[k]) begin
                n_fail++;
                $display("FAIL held_ct[%0d]: got %h want %h", k, ct_mem_a[k], m_ct[k]);
            end
        end
        model_prga(32);
        do_start(1'b0, 1'b0);
        n_cmp++;
        if (done_a !== 1'b0 || busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_edge: got done=%b busy=%b want 0 1", done_a, busy_a);
        end
        wait_done(1'b0, 0, cyc);
        n_cmp++;
        if (cyc !== 288) begin
            n_fail++;
            $display("FAIL restart_done: got %0d cycles want 288", cyc);
        end
        for (int k = 0; k < 32; k++) begin
            n_cmp++;
            if (ct_mem_a[k] !== m_ct[k]) begin
                n_fail++;
                $display("FAIL restart_ct[%0d]: got %h want %h", k, ct_mem_a[k], m_ct[k]);
            end
        end
    endtask

    task automatic test_wrap();
        int cyc, b_ct;
        model_identity();
        for (int x = 0; x < 256; x++) m_pt[x] = 8'($urandom);
        push_init();
        do_load(1'b1);
        model_prga(256);
        b_ct = n_ctwr_b;
        do_start(1'b1, 1'b0);
        wait_done(1'b1, 0, cyc);
        @(negedge clk);
        n_cmp++;
        if (cyc !== 2304) begin
            n_fail++;
            $display("FAIL wrap_done: got %0d cycles want 2304", cyc);
        end
        n_cmp++;
        if (n_ctwr_b - b_ct !== 256 || last_ct_b !== 255) begin
            n_fail++;
            $display("FAIL wrap_writes: got n=%0d last=%0d want 256 255", n_ctwr_b - b_ct, last_ct_b);
        end
        for (int k = 0; k < 256; k++) begin
            n_cmp++;
            if (ct_mem_b[k] !== m_ct[k]) begin
                n_fail++;
                $display("FAIL wrap_ct[%0d]: got %h want %h", k, ct_mem_b[k], m_ct[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_timing();
        test_random();
        test_roundtrip();
        test_reset_mid();
        test_start_held();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
